// File: rtl/sequence_controller_pkg.sv
// Shared types and constants for the sequence controller and its step counter.
// Table words carry the sequence value in the low bits and two flags above it.
package sequence_controller_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch0,
    StFetch1,
    StRun,
    StDone
  } seq_state_e;

  // Flag positions as offsets above the DATA_W-wide sequence value
  localparam int unsigned DynOffsetOfs = 0;
  localparam int unsigned DisableDacOfs = 1;

  localparam logic SafeDynOffsetDisable = 1'b1;
  localparam logic SafeDisableDac = 1'b1;

endpackage

// File: rtl/seq_step_counter.sv
// 32-bit loadable down-counter with a zero flag; holds at zero until reloaded.
module seq_step_counter (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        dec,
  output logic        zero
);

  logic [31:0] count_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 32'd1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sequence_controller.sv
// Steps a sequence value and its control flags through an external table RAM,
// holding each entry for a programmable number of samples.
module sequence_controller
  import sequence_controller_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     enable,
  input  logic [31:0]              step_len,
  input  logic [ADDR_W-1:0]        last_idx,
  input  logic [15:0]              repetitions,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W+1:0]        mem_data,
  output logic signed [DATA_W-1:0] seq_out,
  output logic                     dyn_offset_disable,
  output logic                     disable_dac,
  output logic                     step_strobe,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        cur_idx,
  output logic [15:0]              cur_rep
);

  seq_state_e state_q, state_d;

  logic [31:0]       step_len_q;
  logic [ADDR_W-1:0] last_q;
  logic [15:0]       reps_q;
  logic [ADDR_W-1:0] mem_addr_q, cur_idx_q, addr_inc, idx_inc;
  logic [15:0]       cur_rep_q;
  logic [DATA_W+1:0] entry_q, pf_q, next_word;
  logic              strobe_q;
  logic              cnt_zero, cnt_load, boundary, final_step;

  assign addr_inc = (mem_addr_q == last_q) ? '0 : mem_addr_q + ADDR_W'(1);
  assign idx_inc  = (cur_idx_q == last_q) ? '0 : cur_idx_q + ADDR_W'(1);

  assign boundary   = (state_q == StRun) && cnt_zero;
  assign final_step = boundary && (reps_q != '0) && (cur_idx_q == last_q) &&
                      (({1'b0, cur_rep_q} + 17'd1) == {1'b0, reps_q});

  // The prefetch register is only filled one cycle into an entry, so a
  // boundary in that first cycle (step_len 1) takes the RAM word directly.
  assign next_word = strobe_q ? mem_data : pf_q;

  assign cnt_load = enable && (((state_q == StFetch1)) || (boundary && !final_step));

  seq_step_counter u_step_counter (
    .clk        (clk),
    .aresetn    (aresetn),
    .load       (cnt_load),
    .load_value (step_len_q - 32'd1),
    .dec        (state_q == StRun),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (enable) state_d = StFetch0;
      StFetch0: state_d = enable ? StFetch1 : StIdle;
      StFetch1: state_d = enable ? StRun : StIdle;
      StRun: begin
        if (!enable)         state_d = StIdle;
        else if (final_step) state_d = StDone;
      end
      StDone:   if (!enable) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // mem_addr runs two entries ahead of cur_idx once RUN is reached
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      step_len_q <= 32'd1;
      last_q     <= '0;
      reps_q     <= '0;
      mem_addr_q <= '0;
      cur_idx_q  <= '0;
      cur_rep_q  <= '0;
      entry_q    <= '0;
      pf_q       <= '0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (enable) begin
        unique case (state_q)
          StIdle: begin
            step_len_q <= (step_len == 32'd0) ? 32'd1 : step_len;
            last_q     <= last_idx;
            reps_q     <= repetitions;
            mem_addr_q <= '0;
            cur_idx_q  <= '0;
            cur_rep_q  <= '0;
          end
          StFetch0: mem_addr_q <= (last_q == '0) ? '0 : ADDR_W'(1);
          StFetch1: begin
            entry_q    <= mem_data;
            strobe_q   <= 1'b1;
            mem_addr_q <= addr_inc;
          end
          StRun: begin
            if (strobe_q) pf_q <= mem_data;
            if (final_step) begin
              cur_rep_q <= cur_rep_q + 16'd1;
            end else if (boundary) begin
              entry_q    <= next_word;
              strobe_q   <= 1'b1;
              mem_addr_q <= addr_inc;
              cur_idx_q  <= idx_inc;
              if ((cur_idx_q == last_q) && (cur_rep_q != 16'hFFFF)) begin
                cur_rep_q <= cur_rep_q + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    seq_out            = '0;
    dyn_offset_disable = SafeDynOffsetDisable;
    disable_dac        = SafeDisableDac;
    if (state_q == StRun) begin
      seq_out            = entry_q[DATA_W-1:0];
      dyn_offset_disable = entry_q[DATA_W+DynOffsetOfs];
      disable_dac        = entry_q[DATA_W+DisableDacOfs];
    end
    step_strobe = strobe_q;
    busy        = state_q inside {StFetch0, StFetch1, StRun};
    done        = (state_q == StDone);
    mem_addr    = mem_addr_q;
    cur_idx     = cur_idx_q;
    cur_rep     = cur_rep_q;
  end

endmodule
